alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Sequential, parametrised successor of the combinational 4-op ALU. Accepts one operation per
//  valid/ready transaction, computes it (single-cycle or iterative), registers result and flags,
//  and holds them until the consumer takes them. Sits between the operand sequencer and the
//  result writeback stage.
// PARAMETERS
//  BITS   8   operand/result width (>=2); shift counter width CW = $clog2(BITS)+1
// PORTS
//  i_clk     in   1     clock; all logic on rising edge
//  i_rst_n   in   1     synchronous, active-low reset
//  i_valid   in   1     operand/op valid
//  o_ready   out  1     block can accept (high only in IDLE)
//  i_a       in   BITS  operand A
//  i_b       in   BITS  operand B / shift amount / bit index
//  i_op      in   3     opcode (see BEHAVIOUR)
//  o_valid   out  1     result valid
//  i_ready   in   1     consumer takes result
//  o_out     out  BITS  result
//  o_carry   out  1     borrow/carry/shifted-out flag
//  o_ERR     out  1     operation error
//  o_even    out  1     count of zero bits in o_out is even
//  o_single  out  1     exactly one zero bit in o_out
// BEHAVIOUR
//  Reset (i_rst_n=0 at an edge): state=IDLE; o_valid,o_out,o_carry,o_ERR,o_single=0; o_even=0;
//   o_ready=1. Reset wins over every other event, aborts any operation in flight.
//  Handshake: accept when i_valid&&o_ready at edge; operands latched, inputs ignored until IDLE.
//   Result leaves when o_valid&&i_ready at edge -> IDLE. o_out/flags stable while o_valid&&!i_ready.
//  FSM: IDLE -accept, 1-cycle op or error-> DONE; IDLE -accept SHL/SHR, 0<b<BITS-> SHIFT;
//   SHIFT -cnt==1-> DONE (else stay, cnt--); DONE -i_ready-> IDLE. o_valid=1 only in DONE.
//  Opcodes (unsigned, all widths BITS, wrap modulo 2^BITS):
//   000 SUB  out=a-b; carry=1 iff a<b (borrow)
//   001 CMP  out={0..,a>b}; carry=0
//   010 SHL  out=a<<b, one bit per SHIFT cycle; carry=OR of all bits shifted out (sticky)
//   011 CHG  out=a with bit b inverted; carry=0
//   100 ADD  out=a+b; carry=carry-out of bit BITS-1
//   101 SHR  logical a>>b, one bit per SHIFT cycle; carry=OR of bits shifted out
//   110/111  illegal: out=0, ERR=1, carry=0, DONE after 1 cycle
//  Errors: SHL/SHR with b>=BITS (full-width compare) -> out=0, ERR=1, carry=0, 1-cycle;
//   CHG with b>=BITS -> out=a unchanged, ERR=1. ERR=0 for all other cases.
//  Shift b=0: no SHIFT state, out=a, carry=0, 1-cycle latency.
//  Latency (accept edge -> first edge with o_valid sampled 1): 1 for 1-cycle ops; b+1 for shifts.
//  Flags computed from final result, registered together with o_out on entry to DONE:
//   zeros=count of 0 bits; o_even=(zeros%2==0); o_single=(zeros==1). Both 0 otherwise;
//   zeros==0 -> o_even=1. Flags also valid for error results.
//  No new accept in DONE, even if i_ready=1 same cycle (back-to-back gap of 1 cycle).
// TESTING
//  1 reset: hold i_rst_n=0 2 edges mid-SHL b=5 -> IDLE, o_valid=0, all outputs 0, o_ready=1.
//  2 SUB a=5 b=7 -> 1 cycle: out=8'hFE, carry=1, ERR=0, single=1, even=0; ADD 8'hFF+1 -> out=0,
//    carry=1, even=1.
//  3 SHL a=8'h81 b=3 -> o_valid on 4th edge, out=8'h08, carry=1, zeros=7 -> even=0,single=0;
//    SHR a=8'h01 b=0 -> 1 cycle, out=8'h01, carry=0.
//  4 errors: SHL b=8 -> out=0,ERR=1,even=1; CHG a=8'hFF b=8 -> out=8'hFF,ERR=1,even=1;
//    op=3'b110 -> ERR=1.
//  5 backpressure: CMP a=9 b=3, i_ready=0 for 5 cycles -> out=8'h01 stable, o_ready=0,
//    i_valid ignored; i_ready=1 -> IDLE next edge.
//  6 random 1000 transactions vs reference model, random i_valid/i_ready, BITS=8 and BITS=13.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential 6-op ALU with valid/ready handshakes on both sides. Shifts iterate one bit per
// cycle, all other ops finish in one cycle; result and zero-count flags are held until taken.
module alu_seq #(
    parameter int BITS = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    input  logic [2:0]      i_op,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [BITS-1:0] o_out,
    output logic            o_carry,
    output logic            o_ERR,
    output logic            o_even,
    output logic            o_single
);

    localparam int CW = $clog2(BITS) + 1;
    localparam logic [BITS:0] LIM = (BITS+1)'(BITS);

    localparam logic [2:0] OP_SUB = 3'b000;
    localparam logic [2:0] OP_CMP = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_CHG = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] sh;
    logic            sc;
    logic            dir;

    logic [BITS-1:0] res;
    logic            res_c;
    logic            res_e;
    logic            go_shift;
    logic [BITS:0]   wide;
    logic            b_big;
    logic [BITS-1:0] one_hot;
    logic [BITS-1:0] sh_nxt;
    logic            sc_nxt;
    logic [BITS-1:0] fin;
    logic            fin_c;
    logic            fin_e;
    logic            load;
    logic            last;

    function automatic int unsigned zero_cnt(input logic [BITS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < BITS; i++) begin
            if (!v[i]) n++;
        end
        return n;
    endfunction

    function automatic logic f_even(input logic [BITS-1:0] v);
        return (zero_cnt(v) & 32'd1) == 32'd0;
    endfunction

    function automatic logic f_single(input logic [BITS-1:0] v);
        return zero_cnt(v) == 32'd1;
    endfunction

    // Out-of-range test uses the full operand width, not just the counter bits
    assign b_big   = {1'b0, i_b} >= LIM;
    assign one_hot = {{(BITS-1){1'b0}}, 1'b1} << i_b;

    always_comb begin
        res      = '0;
        res_c    = 1'b0;
        res_e    = 1'b0;
        go_shift = 1'b0;
        wide     = '0;
        case (i_op)
            OP_SUB: begin
                wide  = {1'b0, i_a} - {1'b0, i_b};
                res   = wide[BITS-1:0];
                res_c = wide[BITS];
            end
            OP_CMP: res = {{(BITS-1){1'b0}}, (i_a > i_b)};
            OP_SHL, OP_SHR: begin
                if (b_big)           res_e    = 1'b1;
                else if (i_b == '0)  res      = i_a;
                else                 go_shift = 1'b1;
            end
            OP_CHG: begin
                res   = b_big ? i_a : (i_a ^ one_hot);
                res_e = b_big;
            end
            OP_ADD: begin
                wide  = {1'b0, i_a} + {1'b0, i_b};
                res   = wide[BITS-1:0];
                res_c = wide[BITS];
            end
            default: res_e = 1'b1;
        endcase
    end

    assign sh_nxt = dir ? (sh >> 1) : (sh << 1);
    assign sc_nxt = sc | (dir ? sh[0] : sh[BITS-1]);
    assign last   = (state == SHIFT) && (cnt == CW'(1));
    assign load   = ((state == IDLE) && i_valid && !go_shift) || last;
    assign fin    = (state == SHIFT) ? sh_nxt : res;
    assign fin_c  = (state == SHIFT) ? sc_nxt : res_c;
    assign fin_e  = (state == SHIFT) ? 1'b0 : res_e;

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            o_out    <= '0;
            o_carry  <= 1'b0;
            o_ERR    <= 1'b0;
            o_even   <= 1'b0;
            o_single <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (go_shift) begin
                            state <= SHIFT;
                            cnt   <= i_b[CW-1:0];
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (last) state <= DONE;
                    else      cnt   <= cnt - 1'b1;
                end
                DONE: begin
                    if (i_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (load) begin
                o_out    <= fin;
                o_carry  <= fin_c;
                o_ERR    <= fin_e;
                o_even   <= f_even(fin);
                o_single <= f_single(fin);
            end
        end
    end

    // Shift working register and sticky shifted-out bit
    always_ff @(posedge i_clk) begin
        if ((state == IDLE) && i_valid) begin
            sh  <= i_a;
            sc  <= 1'b0;
            dir <= (i_op == OP_SHR);
        end else if (state == SHIFT) begin
            sh <= sh_nxt;
            sc <= sc_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, multi-cycle corner sequences and randomized
// traffic on 8- and 13-bit instances against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        valid_s;
    logic        iready_s;
    logic [2:0]  op_s;
    logic [15:0] a_s;
    logic [15:0] b_s;

    logic        rdy8, ov8, c8, e8, ev8, sg8;
    logic [7:0]  out8;
    logic        rdy13, ov13, c13, e13, ev13, sg13;
    logic [12:0] out13;

    logic        rdy_m, ov_m;
    logic [19:0] res_m;

    int total = 0;
    int bad   = 0;

    alu_seq #(.BITS(8)) u8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_s && !sel), .o_ready(rdy8),
        .i_a(a_s[7:0]), .i_b(b_s[7:0]), .i_op(op_s), .o_valid(ov8), .i_ready(iready_s),
        .o_out(out8), .o_carry(c8), .o_ERR(e8), .o_even(ev8), .o_single(sg8)
    );

    alu_seq #(.BITS(13)) u13 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_s && sel), .o_ready(rdy13),
        .i_a(a_s[12:0]), .i_b(b_s[12:0]), .i_op(op_s), .o_valid(ov13), .i_ready(iready_s),
        .o_out(out13), .o_carry(c13), .o_ERR(e13), .o_even(ev13), .o_single(sg13)
    );

    assign rdy_m = sel ? rdy13 : rdy8;
    assign ov_m  = sel ? ov13 : ov8;
    assign res_m = sel ? {3'b0, out13, c13, e13, ev13, sg13} : {8'b0, out8, c8, e8, ev8, sg8};

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic       c;
        logic       e;
        logic       ev;
        logic       sg;
        int         lat;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] out, input logic c, input logic e,
                                input logic ev, input logic sg, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.out = out;
        v.c = c; v.e = e; v.ev = ev; v.sg = sg; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Issue one transaction with i_ready low, return cycles until o_valid appears
    task automatic apply(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
        @(negedge clk);
        op_s = op; a_s = a; b_s = b; valid_s = 1'b1; iready_s = 1'b0;
        @(negedge clk);
        valid_s = 1'b0;
        lat = 1;
        while (!ov_m && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take(input string nm);
        iready_s = 1'b1;
        @(negedge clk);
        iready_s = 1'b0;
        chk(nm, {30'b0, ov_m, rdy_m}, 32'b01);
    endtask

    // Reference: results straight from the opcode definitions using wide integer arithmetic
    task automatic model(input int unsigned a, input int unsigned b, input logic [2:0] op,
                         input int nb, output logic [19:0] r, output int lat);
        longint unsigned m, o, t;
        logic c, e;
        int z;
        m = (64'd1 << nb) - 64'd1;
        o = 0; c = 1'b0; e = 1'b0; lat = 1;
        case (op)
            3'd0: begin o = (64'(a) - 64'(b)) & m; c = (a < b); end
            3'd1: o = (a > b) ? 64'd1 : 64'd0;
            3'd2, 3'd5: begin
                if (b >= 32'(nb)) e = 1'b1;
                else if (b == 0) o = 64'(a);
                else begin
                    lat = int'(b) + 1;
                    if (op == 3'd2) begin
                        t = 64'(a) << b;
                        o = t & m;
                        c = (t >> nb) != 0;
                    end else begin
                        o = 64'(a) >> b;
                        c = (64'(a) & ((64'd1 << b) - 64'd1)) != 0;
                    end
                end
            end
            3'd3: begin
                if (b >= 32'(nb)) begin o = 64'(a); e = 1'b1; end
                else o = 64'(a) ^ (64'd1 << b);
            end
            3'd4: begin t = 64'(a) + 64'(b); o = t & m; c = (t >> nb) != 0; end
            default: e = 1'b1;
        endcase
        z = nb - $countones(o);
        r = {o[15:0], c, e, (z % 2) == 0, z == 1};
    endtask

    task automatic rand_run(input logic s, input int nb, input int ntx);
        int          done, iter, due, lat;
        logic        pending;
        logic [19:0] expv;
        int unsigned a, b, mask;
        logic [2:0]  op;
        sel = s; valid_s = 1'b0; iready_s = 1'b0;
        mask = (32'd1 << nb) - 32'd1;
        done = 0; iter = 0; due = 0; pending = 1'b0; expv = '0;
        @(negedge clk);
        while (done < ntx && iter < 40000) begin
            @(negedge clk);
            iter++;
            chk("rand_handshake", {30'b0, ov_m, rdy_m}, {30'b0, pending && (iter >= due), !pending});
            if (pending && iter >= due) chk("rand_result", {12'b0, res_m}, {12'b0, expv});
            iready_s = ($urandom_range(0, 2) != 0);
            valid_s  = ($urandom_range(0, 3) != 0);
            a  = $urandom & mask;
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) b = $urandom & mask;
            else                           b = $urandom_range(0, nb + 1);
            a_s = a[15:0]; b_s = b[15:0]; op_s = op;
            if (pending && iter >= due) begin
                if (iready_s) begin
                    pending = 1'b0;
                    done++;
                end
            end else if (!pending && valid_s) begin
                model(a, b, op, nb, expv, lat);
                pending = 1'b1;
                due = iter + lat;
            end
        end
        if (done < ntx) chk("rand_timeout", 32'(done), 32'(ntx));
        valid_s = 1'b0; iready_s = 1'b1;
        repeat (2) @(negedge clk);
        iready_s = 1'b0;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; sel = 1'b0; valid_s = 1'b0; iready_s = 1'b0;
        op_s = '0; a_s = '0; b_s = '0;

        tbl[0]  = mk(3'b000, 8'h05, 8'h07, 8'hFE, 1, 0, 0, 1, 1);
        tbl[1]  = mk(3'b100, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0, 1);
        tbl[2]  = mk(3'b010, 8'h81, 8'h03, 8'h08, 1, 0, 0, 0, 4);
        tbl[3]  = mk(3'b101, 8'h01, 8'h00, 8'h01, 0, 0, 0, 0, 1);
        tbl[4]  = mk(3'b010, 8'h5A, 8'h08, 8'h00, 0, 1, 1, 0, 1);
        tbl[5]  = mk(3'b011, 8'hFF, 8'h08, 8'hFF, 0, 1, 1, 0, 1);
        tbl[6]  = mk(3'b110, 8'h12, 8'h03, 8'h00, 0, 1, 1, 0, 1);
        tbl[7]  = mk(3'b001, 8'h09, 8'h03, 8'h01, 0, 0, 0, 0, 1);
        tbl[8]  = mk(3'b011, 8'hFF, 8'h02, 8'hFB, 0, 0, 0, 1, 1);
        tbl[9]  = mk(3'b101, 8'h96, 8'h02, 8'h25, 1, 0, 0, 0, 3);
        tbl[10] = mk(3'b101, 8'h80, 8'h07, 8'h01, 0, 0, 0, 0, 8);
        tbl[11] = mk(3'b001, 8'h03, 8'h09, 8'h00, 0, 0, 1, 0, 1);
        tbl[12] = mk(3'b000, 8'h07, 8'h05, 8'h02, 0, 0, 0, 0, 1);
        tbl[13] = mk(3'b111, 8'h44, 8'h01, 8'h00, 0, 1, 1, 0, 1);
        tbl[14] = mk(3'b101, 8'h77, 8'h80, 8'h00, 0, 1, 1, 0, 1);

        repeat (3) @(negedge clk);
        chk("reset_hs8", {30'b0, ov8, rdy8}, 32'b01);
        chk("reset_out8", {12'b0, 8'b0, out8, c8, e8, ev8, sg8}, 32'b0);
        chk("reset_hs13", {30'b0, ov13, rdy13}, 32'b01);
        chk("reset_out13", {15'b0, out13, c13, e13, ev13, sg13}, 32'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].op, {8'b0, tbl[i].a}, {8'b0, tbl[i].b}, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_result", i), {12'b0, res_m},
                {12'b0, 8'b0, tbl[i].out, tbl[i].c, tbl[i].e, tbl[i].ev, tbl[i].sg});
            take($sformatf("vec%0d_release", i));
        end

        // Backpressure: result held, new requests ignored while DONE
        @(negedge clk);
        op_s = 3'b001; a_s = 16'd9; b_s = 16'd3; valid_s = 1'b1; iready_s = 1'b0;
        @(negedge clk);
        op_s = 3'b100; a_s = 16'd1; b_s = 16'd1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_hs", {30'b0, ov_m, rdy_m}, 32'b10);
            chk("bp_hold_result", {12'b0, res_m}, {12'b0, 8'b0, 8'h01, 4'b0000});
            @(negedge clk);
        end
        iready_s = 1'b1;
        @(negedge clk);
        chk("bp_release", {30'b0, ov_m, rdy_m}, 32'b01);
        valid_s = 1'b0; iready_s = 1'b0;
        @(negedge clk);
        chk("bp_no_accept_in_done", {30'b0, ov_m, rdy_m}, 32'b01);

        // Reset asserted in the middle of a long shift
        op_s = 3'b010; a_s = 16'h81; b_s = 16'd5; valid_s = 1'b1;
        @(negedge clk);
        valid_s = 1'b0;
        @(negedge clk);
        chk("shift_busy", {30'b0, ov_m, rdy_m}, 32'b00);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midshift_reset_hs", {30'b0, ov_m, rdy_m}, 32'b01);
        chk("midshift_reset_out", {12'b0, res_m}, 32'b0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("after_reset_idle", {30'b0, ov_m, rdy_m}, 32'b01);

        rand_run(1'b0, 8, 1000);
        rand_run(1'b1, 13, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
